// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: groups the ROM read port and the decode-side valid/ready port of the prefetch queue.
// Latency: none (wires only).
// Backpressure: instr_ready from the slave (decode) holds the head; the ROM side has no backpressure.
// Signals: rom_addr/rom_q ROM port; instr_valid/instr_ready/instr_out/instr_pc decode handshake.
// Modports: master = prefetch queue, slave = ROM + decode side.
interface instr_prefetch_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [15:0]       instr_pc;

  modport master (
    output rom_addr,
    input  rom_q,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch stage streaming ROM words, tagged with their fetch PC, into a DEPTH-entry queue.
// Latency: first word valid 2 cycles after fetch_en, 3 cycles after redirect; 1 word/cycle at steady state.
// Backpressure: instr_ready low fills the queue; reads are gated on count+inflight<DEPTH so no word is lost.
// Ports: Clock, Resetn (async, active-low); fetch_en run enable; redirect/redirect_pc flush and restart;
//   bus (master modport): rom_addr/rom_q ROM port, instr_valid/instr_ready/instr_out/instr_pc decode port;
//   count/empty/full occupancy. Macro PREFETCH_STATS_EN adds fetch_cnt/flush_cnt saturating counters.
module instr_prefetch_queue #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  instr_prefetch_queue_if.master   bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]              fetch_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       fpc;
  logic [15:0]       tag_pc;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              inflight;
  logic [DATA_W-1:0] mem_dat [DEPTH];
  logic [15:0]       mem_pc  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic valid_w;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A slot is reserved for the read in flight, so a full queue never receives a push.
  assign credit_ok = (count + CNT_W'(inflight)) < DEPTH_C;

  // Issue is gated by fetch_en directly rather than the registered state, so the first
  // read leaves on the same edge that enters S_RUN (or leaves S_FLUSH).
  assign issue = fetch_en && !redirect && credit_ok;

  // The word returning in a redirect cycle belongs to the old path and is dropped.
  assign push    = inflight && !redirect;
  assign valid_w = !empty && (state != S_FLUSH) && !redirect;
  assign pop     = valid_w && bus.instr_ready;

  assign bus.rom_addr    = rom_addr_q;
  assign bus.instr_valid = valid_w;
  assign bus.instr_out   = mem_dat[rd_ptr];
  assign bus.instr_pc    = mem_pc[rd_ptr];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      fpc        <= PC_RESET;
      tag_pc     <= '0;
      rom_addr_q <= PC_RESET[ADDR_W-1:0];
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_pc[i]  <= '0;
      end
    end else if (redirect) begin
      // Flush wins over pop, push and issue; rom_addr keeps its last value.
      state    <= S_FLUSH;
      fpc      <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE:  if (fetch_en)  state <= S_RUN;
        S_RUN:   if (!fetch_en) state <= S_IDLE;
        S_FLUSH: state <= fetch_en ? S_RUN : S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        rom_addr_q <= fpc[ADDR_W-1:0];
        tag_pc     <= fpc;
        fpc        <= fpc + 16'd1;
      end
      // One read in flight at most; it lands the next cycle, so inflight simply tracks issue.
      inflight <= issue;

      if (push) begin
        mem_dat[wr_ptr] <= bus.rom_q;
        mem_pc[wr_ptr]  <= tag_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != 16'hFFFF)) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed scenarios plus random traffic against a queue-level reference model.
// ROM model: rom_q is a lookup of the registered rom_addr, i.e. the DUT address register is the ROM input register.
module tb_instr_prefetch_queue;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [2:0]  count;
  logic        empty;
  logic        full;
`ifdef PREFETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  logic [15:0] rom [32];
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  assign bus.rom_q       = rom[bus.rom_addr];
  assign bus.instr_ready = rdy;

  instr_prefetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PC_RESET(16'h0000)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus), .count(count), .empty(empty), .full(full)
`ifdef PREFETCH_STATS_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 Clock = ~Clock;

  // Reference model: queue of (pc, data) entries, one pending read, next fetch PC.
  typedef struct { logic [15:0] pc; logic [15:0] dat; } ent_t;
  ent_t        mq[$];
  bit          m_pend;
  bit          m_after_rd;
  logic [15:0] m_ppc;
  logic [15:0] m_fpc;
  logic [ADDR_W-1:0] m_raddr;
  int          m_fetches;
  int          m_flushes;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0; m_after_rd = 1'b0;
    m_ppc = 16'h0; m_fpc = 16'h0; m_raddr = '0;
    m_fetches = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    bit v;
    bit can;
    logic [ADDR_W-1:0] idx;
    ent_t e;
    if (!Resetn) begin
      model_reset();
      return;
    end
    if (redirect) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc = redirect_pc;
      m_after_rd = 1'b1;
      if (m_flushes < 65535) m_flushes++;
      return;
    end
    v   = (mq.size() > 0) && !m_after_rd;
    can = fetch_en && ((mq.size() + int'(m_pend)) < DEPTH);
    if (v && rdy) void'(mq.pop_front());
    if (m_pend) begin
      idx = m_ppc[ADDR_W-1:0];
      e.pc = m_ppc;
      e.dat = rom[idx];
      mq.push_back(e);
      if (m_fetches < 65535) m_fetches++;
    end
    if (can) begin
      m_pend = 1'b1;
      m_ppc = m_fpc;
      m_raddr = m_fpc[ADDR_W-1:0];
      m_fpc = m_fpc + 16'd1;
    end else begin
      m_pend = 1'b0;
    end
    m_after_rd = 1'b0;
  endtask

  task automatic compare();
    bit ev;
    ev = (mq.size() > 0) && !m_after_rd && !redirect;
    chk("instr_valid", bus.instr_valid, ev);
    if (ev) begin
      chk("instr_out", bus.instr_out, mq[0].dat);
      chk("instr_pc", bus.instr_pc, mq[0].pc);
    end
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("rom_addr", bus.rom_addr, m_raddr);
`ifdef PREFETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, m_fetches);
    chk("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (chk_en) compare();
    end
  end

  // One cycle with the given inputs; returns 2 time units after the active edge.
  task automatic apply(input bit fe, input bit r, input bit rd, input logic [15:0] rpc);
    fetch_en = fe; rdy = r; redirect = rd; redirect_pc = rpc;
    @(posedge Clock);
    model_step();
    #2;
  endtask

  logic [15:0] t5_pc [4];
  logic [15:0] t5_dat [4];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    t5_pc[0] = 16'hFFFE; t5_pc[1] = 16'hFFFF; t5_pc[2] = 16'h0000; t5_pc[3] = 16'h0001;
    t5_dat[0] = 16'h101E; t5_dat[1] = 16'h101F; t5_dat[2] = 16'h1000; t5_dat[3] = 16'h1001;
    model_reset();

    // Reset state
    #1 Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_out", bus.instr_out, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    Resetn = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // T1/T4: streaming from PC 0 with ready held high
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    apply(1'b0, 1'b1, 1'b0, 16'h0);
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t1_valid_early", bus.instr_valid, 0);
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t1_valid_rise", bus.instr_valid, 1);
    chk("t1_first_out", bus.instr_out, 16'h1000);
    chk("t1_first_pc", bus.instr_pc, 16'h0000);
    chk("t1_rom_addr", bus.rom_addr, 5'd1);
    for (int k = 1; k < 6; k++) begin
      apply(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t1_stream_out", bus.instr_out, 16'h1000 + 16'(k));
      chk("t1_stream_pc", bus.instr_pc, 16'(k));
      chk("t4_valid", bus.instr_valid, 1);
      chk("t4_count", count, 1);
    end

    // T2: fill with ready low, then drain and keep streaming
    apply(1'b1, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 8; k++) apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t2_count", count, 4);
    chk("t2_full", full, 1);
    chk("t2_rom_addr_hold", bus.rom_addr, 5'd3);
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_valid", bus.instr_valid, 1);
      chk("t2_drain_out", bus.instr_out, 16'h1000 + 16'(k));
      chk("t2_drain_pc", bus.instr_pc, 16'(k));
      apply(1'b1, 1'b1, 1'b0, 16'h0);
    end

    // T3: redirect with count=3 and a read in flight
    apply(1'b1, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t3_pre_count", count, 3);
    apply(1'b1, 1'b0, 1'b1, 16'h0010);
    chk("t3_flush_count", count, 0);
    chk("t3_flush_empty", empty, 1);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t3_no_stale", bus.instr_valid, 0);
    chk("t3_rom_addr", bus.rom_addr, 5'd16);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t3_valid", bus.instr_valid, 1);
    chk("t3_out", bus.instr_out, 16'h1010);
    chk("t3_pc", bus.instr_pc, 16'h0010);

    // T5: PC wrap and rom_addr aliasing
    apply(1'b1, 1'b0, 1'b1, 16'hFFFE);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_addr0", bus.rom_addr, 5'd30);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_addr1", bus.rom_addr, 5'd31);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_addr2", bus.rom_addr, 5'd0);
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_addr3", bus.rom_addr, 5'd1);
    for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_full", full, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t5_pc", bus.instr_pc, t5_pc[k]);
      chk("t5_out", bus.instr_out, t5_dat[k]);
      apply(1'b1, 1'b1, 1'b0, 16'h0);
    end

    // T6: async reset mid-stream
    for (int k = 0; k < 5; k++) apply(1'b1, 1'b1, 1'b0, 16'h0);
    Resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", bus.instr_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_out", bus.instr_out, 0);
    chk("t6_pc", bus.instr_pc, 0);
    chk("t6_rom_addr", bus.rom_addr, 0);
`ifdef PREFETCH_STATS_EN
    chk("t6_fetch_cnt", fetch_cnt, 0);
    chk("t6_flush_cnt", flush_cnt, 0);
`endif
    #1;
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    Resetn = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
            ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom));
    end
    apply(1'b0, 1'b1, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
